uart_rx: RTL

- UART receiver; the complementary end of the team's uart_tx. Frame format is 8N1, LSB first, idle-high line.
- Oversamples the asynchronous `rx` pin at 16x baud and majority-votes each bit.
- Delivers bytes with a ready/read handshake and reports framing and overrun errors.
- Sits between the board RX pin and the terminal command/character path.

---
 rtl/uart_rx.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with 16x oversampling and 2-of-3 majority vote.
// Received bytes are handed over with a ready/rd handshake; framing and
// overrun errors are reported as single-cycle pulses.
//
// state   | meaning
// S_IDLE  | line idle, waiting for a falling edge on the synchronized input
// S_START | validating the start bit (false starts return to idle)
// S_DATA  | shifting in eight data bits, LSB first
// S_STOP  | sampling the stop bit; leaves at the mid-bit decision
module uart_rx #(
    parameter int CLKFREQ = 25000000,
    parameter int BAUD    = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       rd,
    output logic [7:0] data,
    output logic       valid,
    output logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int DIV = CLKFREQ / (BAUD * 16);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t          state_q, state_d;
    logic            rx_meta_q, rx_meta_d;
    logic            rx_s_q, rx_s_d;
    logic            rx_prev_q, rx_prev_d;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [3:0]      samp_cnt_q, samp_cnt_d;
    logic [1:0]      votes_q, votes_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            ready_q, ready_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;

    logic            tick;
    logic            fall;
    logic            decide;
    logic            last_pos;
    logic            vote;

    // Oversample tick only runs while a frame is in progress.
    assign tick     = (state_q != S_IDLE) && (tick_cnt_q == TICK_LAST);
    assign fall     = !rx_s_q && rx_prev_q;
    assign decide   = tick && (samp_cnt_q == 4'd9);
    assign last_pos = tick && (samp_cnt_q == 4'd15);
    // Samples from positions 7 and 8 are stored; position 9 is the live input.
    assign vote     = (votes_q[0] & votes_q[1]) | (votes_q[0] & rx_s_q) | (votes_q[1] & rx_s_q);

    // Two-flop synchronizer plus the previous-sample flop for edge detection.
    always_comb begin
        rx_meta_d = rx;
        rx_s_d    = rx_meta_q;
        rx_prev_d = rx_s_q;
    end

    // Next-state, counters, datapath and output pulses.
    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick ? '0 : tick_cnt_q + TW'(1);
        samp_cnt_d  = tick ? samp_cnt_q + 4'd1 : samp_cnt_q;
        votes_d     = votes_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        ready_d     = rd ? 1'b0 : ready_q;

        if (tick && (samp_cnt_q == 4'd7)) begin
            votes_d[0] = rx_s_q;
        end
        if (tick && (samp_cnt_q == 4'd8)) begin
            votes_d[1] = rx_s_q;
        end

        case (state_q)
            S_IDLE: begin
                tick_cnt_d = '0;
                samp_cnt_d = 4'd0;
                if (fall) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (decide && vote) begin
                    state_d = S_IDLE;
                end else if (last_pos) begin
                    state_d   = S_DATA;
                    bit_idx_d = 3'd0;
                end
            end
            S_DATA: begin
                if (decide) begin
                    shift_d = {vote, shift_q[7:1]};
                end
                if (last_pos) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                // Leave mid stop bit so a slightly fast sender's next start edge is not missed.
                if (decide) begin
                    state_d = S_IDLE;
                    if (vote) begin
                        data_d    = shift_q;
                        valid_d   = 1'b1;
                        ready_d   = 1'b1;
                        overrun_d = ready_q && !rd;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Synchronizer register; idles high so reset cannot look like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_meta_d;
            rx_s_q    <= rx_s_d;
            rx_prev_q <= rx_prev_d;
        end
    end

    // State, counters and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            tick_cnt_q  <= '0;
            samp_cnt_q  <= 4'd0;
            votes_q     <= 2'b00;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            ready_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            samp_cnt_q  <= samp_cnt_d;
            votes_q     <= votes_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            ready_q     <= ready_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign ready     = ready_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != S_IDLE);

endmodule
